// File: rtl/axi_read_arbiter.sv
// N-to-1 AXI4 read arbiter (AR/R channels only).
// Round-robin AR grant, ID-prefix R routing, per-master burst limit.
module axi_read_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_BITS       = 32,
  parameter int DATA_BITS       = 64,
  parameter int ID_BITS         = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int G_BITS         = $clog2(N_MASTERS),
  localparam int SID_BITS       = ID_BITS + G_BITS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_MASTERS-1:0]           m_ar_valid,
  output logic [N_MASTERS-1:0]           m_ar_ready,
  input  logic [N_MASTERS*ADDR_BITS-1:0] m_ar_addr,
  input  logic [N_MASTERS*8-1:0]         m_ar_len,
  input  logic [N_MASTERS*3-1:0]         m_ar_size,
  input  logic [N_MASTERS*ID_BITS-1:0]   m_ar_id,
  output logic [N_MASTERS-1:0]           m_r_valid,
  input  logic [N_MASTERS-1:0]           m_r_ready,
  output logic [DATA_BITS-1:0]           m_r_data,
  output logic [1:0]                     m_r_resp,
  output logic                           m_r_last,
  output logic [ID_BITS-1:0]             m_r_id,
  output logic                           s_ar_valid,
  input  logic                           s_ar_ready,
  output logic [ADDR_BITS-1:0]           s_ar_addr,
  output logic [7:0]                     s_ar_len,
  output logic [2:0]                     s_ar_size,
  output logic [SID_BITS-1:0]            s_ar_id,
  input  logic                           s_r_valid,
  output logic                           s_r_ready,
  input  logic [DATA_BITS-1:0]           s_r_data,
  input  logic [1:0]                     s_r_resp,
  input  logic                           s_r_last,
  input  logic [SID_BITS-1:0]            s_r_id,
  output logic                           err_bad_id
);

  localparam int IDX_W = (G_BITS > 0) ? G_BITS : 1;
  localparam int CW    = 4;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    ptr;
  logic [CW-1:0]       cnt [N_MASTERS];

  logic [N_MASTERS-1:0] elig;
  logic                 found;
  logic [IDX_W-1:0]     pick;

  logic                 sel_valid;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [7:0]           sel_len;
  logic [2:0]           sel_size;
  logic [ID_BITS-1:0]   sel_id;

  logic [IDX_W-1:0]     dest;
  logic                 dest_ok;
  logic                 ar_hs;
  logic                 r_hs;
  logic [N_MASTERS-1:0] inc;
  logic [N_MASTERS-1:0] dec;

  // Slave ID layout depends on whether a grant field exists at all
  if (G_BITS > 0) begin : g_multi
    assign dest    = s_r_id[SID_BITS-1:ID_BITS];
    assign dest_ok = (32'(dest) < 32'(N_MASTERS));
    assign s_ar_id = {grant, sel_id};
  end else begin : g_single
    assign dest    = '0;
    assign dest_ok = 1'b1;
    assign s_ar_id = sel_id;
  end

  // Eligibility: requesting and below the per-master burst limit
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      elig[i] = m_ar_valid[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
    end
  end

  // Round-robin scan starting at ptr
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(ptr) + k) % N_MASTERS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // Mux the locked master's AR fields toward the slave
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_id    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_valid = m_ar_valid[i];
        sel_addr  = m_ar_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_len   = m_ar_len[i*8 +: 8];
        sel_size  = m_ar_size[i*3 +: 3];
        sel_id    = m_ar_id[i*ID_BITS +: ID_BITS];
      end
    end
  end

  assign s_ar_valid = (state == LOCKED) && sel_valid;
  assign s_ar_addr  = sel_addr;
  assign s_ar_len   = sel_len;
  assign s_ar_size  = sel_size;
  assign ar_hs      = s_ar_valid && s_ar_ready;

  // Only the locked master sees the slave's AR ready
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ar_ready[i] = (state == LOCKED) &&
                      (grant == IDX_W'(i)) && s_ar_ready;
    end
  end

  // R routing by the upper ID bits; bad destinations are sunk
  always_comb begin
    m_r_valid = '0;
    s_r_ready = !dest_ok;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (dest_ok && dest == IDX_W'(i)) begin
        m_r_valid[i] = s_r_valid;
        s_r_ready    = m_r_ready[i];
      end
    end
  end

  assign m_r_data = s_r_data;
  assign m_r_resp = s_r_resp;
  assign m_r_last = s_r_last;
  assign m_r_id   = s_r_id[ID_BITS-1:0];
  assign r_hs     = s_r_valid && s_r_ready;

  // Per-master count events for this cycle
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      inc[i] = ar_hs && (grant == IDX_W'(i));
      dec[i] = r_hs && s_r_last && dest_ok &&
               (dest == IDX_W'(i));
    end
  end

  // AR grant FSM: arbitrate in IDLE, hold grant until handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (ar_hs) begin
            if (grant == IDX_W'(N_MASTERS - 1)) ptr <= '0;
            else ptr <= grant + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding-burst counters, saturating at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_MASTERS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        assert (!(dec[i] && !inc[i] && cnt[i] == '0))
          else $error("outstanding count underflow on master %0d", i);
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Sticky flag for R beats addressed to a nonexistent master
  always_ff @(posedge clock) begin
    if (reset) begin
      err_bad_id <= 1'b0;
    end else if (r_hs && !dest_ok) begin
      err_bad_id <= 1'b1;
    end
  end

endmodule
